mem_arbiter2: RTL and testbench
===============================

# mem_arbiter2

Two-master arbiter sharing the core's single native memory port (valid/ready, 32-bit address/data, byte write strobes) between the CPU control path and a second bus master (DMA / video fetch). It grants one requester at a time with round-robin fairness and holds the grant until the slave completes the access. A per-access watchdog terminates hung accesses with an error pulse. It sits between the core's memory interface and the SoC memory/peripheral decoder.

## Interface
- TIMEOUT, 1024, max granted cycles without mem_ready before forced abort; 0 disables watchdog; legal 0..65535
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- cpu_valid  in  1  CPU request; held high until cpu_ready
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_wstrb  in  4  CPU byte strobes; 0 = read
- cpu_rdata  out  32  read data to CPU
- cpu_ready  out  1  CPU access complete (1-cycle)
- dma_valid, dma_addr, dma_wdata, dma_wstrb  in  1/32/32/4  second master, same semantics
- dma_rdata  out  32  read data to DMA
- dma_ready  out  1  DMA access complete (1-cycle)
- mem_valid  out  1  request to memory slave
- mem_addr  out  32  muxed address of granted master
- mem_wdata  out  32  muxed write data
- mem_wstrb  out  4  muxed strobes
- mem_rdata  in  32  slave read data, valid with mem_ready
- mem_ready  in  1  slave completion
- timeout_err  out  1  one-cycle pulse on watchdog abort
- grant_dma  out  1  current owner (0 = CPU), debug/observability

## Operation
- States: IDLE, GNT_CPU, GNT_DMA. Registers: state, last_grant (1 bit), wd_cnt (16 bit), timeout_err.
- IDLE: mem_valid=0. Only cpu_valid -> GNT_CPU; only dma_valid -> GNT_DMA; both -> grant the master not equal to last_grant; neither -> stay.
- On entry to GNT_x: last_grant <= x, wd_cnt <= 0.
- GNT_x: mem_valid=1; mem_addr/wdata/wstrb = master x's inputs; x_ready = mem_ready; x_rdata = mem_rdata; other master's ready=0. Non-granted rdata outputs = 0.
- mem_ready in GNT_x -> IDLE next cycle (mandatory one-cycle turnaround so the served master's valid can drop).
- No mem_ready: wd_cnt increments. If TIMEOUT!=0 and wd_cnt==TIMEOUT-1 without mem_ready: x_ready=1, x_rdata=32'hFFFF_FFFF this cycle, timeout_err=1 next cycle, state -> IDLE.
- mem_ready and timeout in same cycle: normal completion, no error, real mem_rdata.
- Master deasserting valid while granted is a protocol violation; arbiter keeps mem_valid asserted until completion or timeout (no abort).
- Outputs mem_addr/wdata/wstrb in IDLE: driven from CPU inputs (don't-care, deterministic).

## Timing
- Reset (async assert, sync deassert by clk domain): state=IDLE, last_grant=1 (CPU wins first tie), wd_cnt=0, timeout_err=0; hence mem_valid=0, cpu_ready=0, dma_ready=0, grant_dma=0.
- Reset asserted mid-access: all outputs return to reset values immediately; access is dropped, no ready issued.
- Grant latency: valid sampled high in IDLE at edge t -> mem_valid high in cycle t+1.
- mem_valid, grant_dma are decoded from state only (registered); ready/rdata are combinational from mem_ready/mem_rdata (zero added latency).
- Zero-wait slave: 2 cycles per access (grant + turnaround); back-to-back alternating masters sustain 1 access / 2 cycles.
- Timeout abort occurs in the TIMEOUT-th granted cycle; timeout_err pulses the following cycle (IDLE).

## Test plan
- Single CPU read, slave ready after 3 cycles, mem_rdata=0x1234_5678 -> mem_valid high 3 cycles with mem_addr=cpu_addr, cpu_ready 1 cycle, cpu_rdata=0x1234_5678, dma_ready never high, then IDLE.
- Both valid from reset, zero-wait slave -> grant order CPU, DMA, CPU, DMA; each access 2 cycles; mem_wstrb/addr match granted master every granted cycle.
- CPU continuously requesting, DMA raises valid during a CPU access -> DMA granted immediately after that access's turnaround; CPU never gets two consecutive grants while DMA pending.
- TIMEOUT=8, DMA write with mem_ready stuck 0 -> dma_ready=1 and dma_rdata=0xFFFF_FFFF in 8th granted cycle, timeout_err pulse next cycle, then CPU pending request granted normally.
- mem_ready coinciding with wd_cnt==TIMEOUT-1 -> normal completion, timeout_err stays 0.
- resetn pulsed low mid-DMA access -> mem_valid and all readies 0 asynchronously; after release, tie resolves to CPU first.

Source files
------------

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin arbiter sharing one valid/ready memory port
// between the CPU and a second bus master, with a per-access watchdog.
module mem_arbiter2 #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_valid,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wstrb,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err,
  output logic        grant_dma
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } state_t;

  // Watchdog count value seen in the last allowed granted cycle.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  localparam bit          WD_ON   = (TIMEOUT != 0);

  state_t      state;
  logic        last_grant;
  logic [15:0] wd_cnt;
  logic        granted;
  logic        wd_hit;
  logic [31:0] served_rdata;

  // A timeout only fires when the slave has not completed in the same cycle.
  always_comb begin
    granted      = (state == GNT_CPU) || (state == GNT_DMA);
    wd_hit       = WD_ON && granted && !mem_ready && (wd_cnt == WD_LAST);
    served_rdata = wd_hit ? 32'hFFFF_FFFF : mem_rdata;
  end

  // Master-side and slave-side muxing; the request is decoded from state only.
  always_comb begin
    mem_valid = granted;
    grant_dma = (state == GNT_DMA);
    if (state == GNT_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_wstrb = dma_wstrb;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wstrb = cpu_wstrb;
    end
    cpu_ready = (state == GNT_CPU) && (mem_ready || wd_hit);
    dma_ready = (state == GNT_DMA) && (mem_ready || wd_hit);
    cpu_rdata = (state == GNT_CPU) ? served_rdata : 32'h0;
    dma_rdata = (state == GNT_DMA) ? served_rdata : 32'h0;
  end

  // Grant FSM: round-robin on ties, hold until completion or watchdog abort,
  // always returning to IDLE for one turnaround cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      wd_cnt      <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_valid && (!dma_valid || last_grant)) begin
            state      <= GNT_CPU;
            last_grant <= 1'b0;
            wd_cnt     <= 16'd0;
          end else if (dma_valid) begin
            state      <= GNT_DMA;
            last_grant <= 1'b1;
            wd_cnt     <= 16'd0;
          end
        end
        GNT_CPU, GNT_DMA: begin
          if (mem_ready) begin
            state <= IDLE;
          end else if (wd_hit) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with an 8-cycle watchdog.
module tb_mem_arbiter2;

  logic        clk;
  logic        resetn;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        dma_valid;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wstrb;
  logic [31:0] dma_rdata;
  logic        dma_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timeout_err;
  logic        grant_dma;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter2 #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .grant_dma(grant_dma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    resetn    = 1'b0;
    cpu_valid = 1'b0; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hC0C0_C0C0; cpu_wstrb = 4'h0;
    dma_valid = 1'b0; dma_addr = 32'h0000_0200; dma_wdata = 32'hD0D0_D0D0; dma_wstrb = 4'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #3;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_dma_ready", dma_ready, 0);
    check("rst_grant_dma", grant_dma, 0);
    check("rst_timeout_err", timeout_err, 0);
    tick; resetn = 1'b1;

    // Single CPU read, slave completes in the third granted cycle.
    tick; cpu_valid = 1'b1; #1;
    tick; #1;
    check("t1_c1_mem_valid", mem_valid, 1);
    check("t1_c1_mem_addr", mem_addr, 32'h0000_0100);
    check("t1_c1_cpu_ready", cpu_ready, 0);
    check("t1_c1_grant_dma", grant_dma, 0);
    tick; #1;
    check("t1_c2_mem_valid", mem_valid, 1);
    tick; mem_ready = 1'b1; mem_rdata = 32'h1234_5678; #1;
    check("t1_c3_mem_valid", mem_valid, 1);
    check("t1_c3_cpu_ready", cpu_ready, 1);
    check("t1_c3_cpu_rdata", cpu_rdata, 32'h1234_5678);
    check("t1_c3_dma_ready", dma_ready, 0);
    check("t1_c3_dma_rdata", dma_rdata, 32'h0);
    tick; cpu_valid = 1'b0; mem_ready = 1'b0; #1;
    check("t1_idle_mem_valid", mem_valid, 0);
    check("t1_idle_cpu_ready", cpu_ready, 0);

    // Fresh reset, then both masters request against a zero-wait slave.
    resetn = 1'b0; #1; resetn = 1'b1;
    cpu_addr = 32'h0000_00A0; cpu_wstrb = 4'hF;
    dma_addr = 32'h0000_00B0; dma_wstrb = 4'h3;
    cpu_valid = 1'b1; dma_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hAAAA_0000;
    for (int k = 0; k < 4; k++) begin
      tick; #1;
      check("t2_grant_dma", grant_dma, k[0]);
      check("t2_mem_valid", mem_valid, 1);
      check("t2_mem_addr", mem_addr, k[0] ? 32'h0000_00B0 : 32'h0000_00A0);
      check("t2_mem_wstrb", mem_wstrb, k[0] ? 4'h3 : 4'hF);
      check("t2_cpu_ready", cpu_ready, !k[0]);
      check("t2_dma_ready", dma_ready, k[0]);
      tick; #1;
      check("t2_turn_mem_valid", mem_valid, 0);
    end
    cpu_valid = 1'b0; dma_valid = 1'b0; mem_ready = 1'b0;

    // CPU busy; DMA arrives mid-access and must win the next grant.
    tick; cpu_valid = 1'b1; #1;
    tick; #1;
    check("t3_cpu_grant", grant_dma, 0);
    tick; dma_valid = 1'b1; #1;
    check("t3_cpu_hold", mem_valid, 1);
    tick; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    check("t3_cpu_ready", cpu_ready, 1);
    check("t3_dma_ready_while_cpu", dma_ready, 0);
    tick; mem_ready = 1'b0; #1;
    check("t3_turn_mem_valid", mem_valid, 0);
    tick; #1;
    check("t3_dma_granted", grant_dma, 1);
    tick; mem_ready = 1'b1; #1;
    check("t3_dma_ready", dma_ready, 1);
    tick; mem_ready = 1'b0; #1;
    tick; #1;
    check("t3_cpu_next", grant_dma, 0);
    mem_ready = 1'b1; #1;
    check("t3_cpu_ready2", cpu_ready, 1);
    tick; mem_ready = 1'b0; dma_wstrb = 4'hF; #1;

    // DMA write against a hung slave: abort in the eighth granted cycle.
    tick; mem_rdata = 32'h1111_1111; #1;
    check("t4_dma_granted", grant_dma, 1);
    for (int i = 2; i <= 7; i++) begin
      tick; #1;
      check("t4_no_ready", dma_ready, 0);
      check("t4_no_err", timeout_err, 0);
    end
    tick; #1;
    check("t4_abort_ready", dma_ready, 1);
    check("t4_abort_rdata", dma_rdata, 32'hFFFF_FFFF);
    check("t4_abort_cpu_rdata", cpu_rdata, 32'h0);
    check("t4_abort_mem_valid", mem_valid, 1);
    check("t4_abort_err_now", timeout_err, 0);
    tick; dma_valid = 1'b0; #1;
    check("t4_err_pulse", timeout_err, 1);
    check("t4_err_idle", mem_valid, 0);
    tick; #1;
    check("t4_cpu_granted", grant_dma, 0);
    check("t4_cpu_mem_valid", mem_valid, 1);
    check("t4_err_cleared", timeout_err, 0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    check("t4_cpu_rdata", cpu_rdata, 32'hCAFE_0001);
    tick; cpu_valid = 1'b0; mem_ready = 1'b0; #1;

    // Completion in the same cycle the watchdog would expire.
    tick; dma_valid = 1'b1; #1;
    for (int i = 1; i <= 7; i++) begin
      tick; #1;
      check("t5_waiting", dma_ready, 0);
    end
    tick; mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA; #1;
    check("t5_ready", dma_ready, 1);
    check("t5_rdata", dma_rdata, 32'h55AA_55AA);
    tick; dma_valid = 1'b0; mem_ready = 1'b0; #1;
    check("t5_no_err", timeout_err, 0);

    // Reset in the middle of a DMA access, then CPU wins the first tie.
    tick; dma_valid = 1'b1; #1;
    tick; mem_ready = 1'b1; #1;
    check("t6_pre_dma_ready", dma_ready, 1);
    resetn = 1'b0; #1;
    check("t6_rst_mem_valid", mem_valid, 0);
    check("t6_rst_dma_ready", dma_ready, 0);
    check("t6_rst_grant_dma", grant_dma, 0);
    tick; resetn = 1'b1; cpu_valid = 1'b1; dma_valid = 1'b1; mem_ready = 1'b0; #1;
    tick; #1;
    check("t6_tie_cpu", grant_dma, 0);
    check("t6_tie_mem_valid", mem_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
